uart_register_bridge: RTL and testbench



---
 rtl/uart_bridge_pkg.sv | 16 +
 rtl/uart_tx_sequencer.sv | 67 ++++++
 rtl/uart_register_bridge.sv | 153 +++++++++++++++
 tb/tb_uart_register_bridge.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared constants and types for the UART command parser and its register bank.
package uart_bridge_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] RSP_ACK   = 8'h06;
   localparam logic [7:0] RSP_NAK   = 8'h15;

   typedef enum logic [2:0] {IDLE, ADDR, WDATA, COMMIT, RESP} bridgeState_e;

   // Full 8-bit compare so out-of-range addresses never alias onto a real register.
   function automatic logic addrInRange(input logic [7:0] addr, input int unsigned numRegs);
      return {24'd0, addr} < numRegs;
   endfunction

endpackage

// File: rtl/uart_tx_sequencer.sv
// Sends up to DATA_BYTES response bytes, MSB first, using the UART send/busy handshake.
module uart_tx_sequencer #(
   parameter int unsigned DATA_BYTES = 4
) (
   input  logic                            ipClk,
   input  logic                            ipReset,
   input  logic                            ipStart,
   input  logic [8*DATA_BYTES-1:0]         ipData,
   input  logic [$clog2(DATA_BYTES+1)-1:0] ipLength,
   input  logic                            ipTxBusy,
   output logic [7:0]                      opTxData,
   output logic                            opTxSend,
   output logic                            opDone
);

   localparam int unsigned W    = 8*DATA_BYTES;
   localparam int unsigned LenW = $clog2(DATA_BYTES+1);

   logic [W-1:0]    shiftReg;
   logic [LenW-1:0] remaining;
   logic            active;

   always_ff @(posedge ipClk) begin
      if (ipReset) begin
         shiftReg  <= '0;
         remaining <= '0;
         active    <= 1'b0;
         opTxData  <= 8'd0;
         opTxSend  <= 1'b0;
         opDone    <= 1'b0;
      end else begin
         opDone <= 1'b0;
         if (ipStart && !active) begin
            active <= 1'b1;
            // Launch the first byte on the start edge when the UART is free.
            if (!ipTxBusy && ipLength != '0) begin
               opTxData  <= ipData[W-1 -: 8];
               opTxSend  <= 1'b1;
               shiftReg  <= ipData << 8;
               remaining <= ipLength - LenW'(1);
            end else begin
               shiftReg  <= ipData;
               remaining <= ipLength;
            end
         end else if (active) begin
            if (opTxSend) begin
               if (ipTxBusy) begin
                  opTxSend <= 1'b0;
                  if (remaining == '0) begin
                     active <= 1'b0;
                     opDone <= 1'b1;
                  end
               end
            end else if (remaining == '0) begin
               active <= 1'b0;
               opDone <= 1'b1;
            end else if (!ipTxBusy) begin
               opTxData  <= shiftReg[W-1 -: 8];
               opTxSend  <= 1'b1;
               shiftReg  <= shiftReg << 8;
               remaining <= remaining - LenW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/uart_register_bridge.sv
// Framed write/read command parser driving a register bank from UART Rx bytes,
// with ACK/NAK or read-data responses and an inter-byte timeout.
module uart_register_bridge
   import uart_bridge_pkg::*;
#(
   parameter int unsigned NUM_REGS       = 16,
   parameter int unsigned DATA_BYTES     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
   input  logic                             ipClk,
   input  logic                             ipReset,
   input  logic [7:0]                       ipRxData,
   input  logic                             ipRxValid,
   output logic [7:0]                       opTxData,
   output logic                             opTxSend,
   input  logic                             ipTxBusy,
   output logic [NUM_REGS*8*DATA_BYTES-1:0] opRegisters,
   output logic                             opWrStrobe,
   output logic [7:0]                       opWrAddress
);

   localparam int unsigned W      = 8*DATA_BYTES;
   localparam int unsigned LenW   = $clog2(DATA_BYTES+1);
   localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES+1);
   localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TIMEOUT_CYCLES-1);
   localparam logic [LenW-1:0]   LastByte    = LenW'(DATA_BYTES-1);

   bridgeState_e    state;
   logic            isWrite;
   logic [7:0]      addr;
   logic [W-1:0]    shiftData;
   logic [LenW-1:0] byteCount;
   logic [TimerW-1:0] timer;
   logic [W-1:0]    regBank [NUM_REGS];

   logic            txStart;
   logic            txDone;
   logic [W-1:0]    txData;
   logic [LenW-1:0] txLen;
   logic [W-1:0]    readWord;

   for (genvar g = 0; g < NUM_REGS; g++) begin : gRegOut
      assign opRegisters[g*W +: W] = regBank[g];
   end

   // Responses start combinationally so the first send rises right after ADDR/COMMIT.
   always_comb begin
      readWord = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (ipRxData == 8'(i)) readWord = regBank[i];
      end
      txStart = 1'b0;
      txData  = '0;
      txLen   = '0;
      if (state == COMMIT) begin
         txStart = 1'b1;
         txData  = W'(addrInRange(addr, NUM_REGS) ? RSP_ACK : RSP_NAK) << (W-8);
         txLen   = LenW'(1);
      end else if (state == ADDR && ipRxValid && !isWrite) begin
         txStart = 1'b1;
         if (addrInRange(ipRxData, NUM_REGS)) begin
            txData = readWord;
            txLen  = LenW'(DATA_BYTES);
         end else begin
            txData = W'(RSP_NAK) << (W-8);
            txLen  = LenW'(1);
         end
      end
   end

   always_ff @(posedge ipClk) begin
      if (ipReset) begin
         state       <= IDLE;
         isWrite     <= 1'b0;
         addr        <= 8'd0;
         shiftData   <= '0;
         byteCount   <= '0;
         timer       <= '0;
         opWrStrobe  <= 1'b0;
         opWrAddress <= 8'd0;
         for (int i = 0; i < NUM_REGS; i++) regBank[i] <= '0;
      end else begin
         opWrStrobe <= 1'b0;
         case (state)
            IDLE: begin
               timer <= '0;
               if (ipRxValid && (ipRxData == CMD_WRITE || ipRxData == CMD_READ)) begin
                  isWrite <= (ipRxData == CMD_WRITE);
                  state   <= ADDR;
               end
            end
            ADDR: begin
               if (ipRxValid) begin
                  addr      <= ipRxData;
                  timer     <= '0;
                  byteCount <= '0;
                  state     <= isWrite ? WDATA : RESP;
               end else if (timer == TimeoutLast) begin
                  timer <= '0;
                  state <= IDLE;
               end else begin
                  timer <= timer + TimerW'(1);
               end
            end
            WDATA: begin
               if (ipRxValid) begin
                  shiftData <= (shiftData << 8) | W'(ipRxData);
                  byteCount <= byteCount + LenW'(1);
                  timer     <= '0;
                  if (byteCount == LastByte) state <= COMMIT;
               end else if (timer == TimeoutLast) begin
                  timer     <= '0;
                  shiftData <= '0;
                  state     <= IDLE;
               end else begin
                  timer <= timer + TimerW'(1);
               end
            end
            COMMIT: begin
               timer <= '0;
               if (addrInRange(addr, NUM_REGS)) begin
                  for (int i = 0; i < NUM_REGS; i++) begin
                     if (addr == 8'(i)) regBank[i] <= shiftData;
                  end
                  opWrStrobe  <= 1'b1;
                  opWrAddress <= addr;
               end
               state <= RESP;
            end
            RESP: begin
               timer <= '0;
               if (txDone) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   uart_tx_sequencer #(
      .DATA_BYTES(DATA_BYTES)
   ) uTxSeq (
      .ipClk   (ipClk),
      .ipReset (ipReset),
      .ipStart (txStart),
      .ipData  (txData),
      .ipLength(txLen),
      .ipTxBusy(ipTxBusy),
      .opTxData(opTxData),
      .opTxSend(opTxSend),
      .opDone  (txDone)
   );

endmodule

// File: tb/tb_uart_register_bridge.sv
// Directed bench for uart_register_bridge: vector table plus timing/timeout/reset sequences.
module tb_uart_register_bridge;

   localparam int unsigned NumRegs   = 4;
   localparam int unsigned DataBytes = 2;
   localparam int unsigned Timeout   = 1000;

   logic        ipClk = 1'b0;
   logic        ipReset = 1'b1;
   logic [7:0]  ipRxData = 8'd0;
   logic        ipRxValid = 1'b0;
   logic        ipTxBusy;
   logic [7:0]  opTxData;
   logic        opTxSend;
   logic [63:0] opRegisters;
   logic        opWrStrobe;
   logic [7:0]  opWrAddress;

   uart_register_bridge #(
      .NUM_REGS      (NumRegs),
      .DATA_BYTES    (DataBytes),
      .TIMEOUT_CYCLES(Timeout)
   ) dut (
      .ipClk      (ipClk),
      .ipReset    (ipReset),
      .ipRxData   (ipRxData),
      .ipRxValid  (ipRxValid),
      .opTxData   (opTxData),
      .opTxSend   (opTxSend),
      .ipTxBusy   (ipTxBusy),
      .opRegisters(opRegisters),
      .opWrStrobe (opWrStrobe),
      .opWrAddress(opWrAddress)
   );

   always #5 ipClk = ~ipClk;

   // UART model: accepts a byte when send is seen idle, then stays busy 10 cycles.
   int         busyCnt = 0;
   logic [7:0] txLog [$];
   always @(posedge ipClk) begin
      if (ipReset) busyCnt <= 0;
      else if (busyCnt != 0) busyCnt <= busyCnt - 1;
      else if (opTxSend) begin
         busyCnt <= 10;
         txLog.push_back(opTxData);
      end
   end
   assign ipTxBusy = (busyCnt != 0);

   int         strobeCount = 0;
   int         sendCycles = 0;
   int         protoErr = 0;
   logic       prevSendBusy = 1'b0;
   logic       prevSend = 1'b0;
   logic [7:0] prevData = 8'd0;
   always @(posedge ipClk) begin
      if (ipReset) begin
         prevSendBusy <= 1'b0;
         prevSend     <= 1'b0;
      end else begin
         if (opWrStrobe) strobeCount <= strobeCount + 1;
         if (opTxSend) sendCycles <= sendCycles + 1;
         if ((opTxSend && ipTxBusy && prevSendBusy) ||
             (opTxSend && prevSend && opTxData != prevData)) protoErr <= protoErr + 1;
         prevSendBusy <= opTxSend && ipTxBusy;
         prevSend     <= opTxSend;
         prevData     <= opTxData;
      end
   end

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic rxByte(input logic [7:0] b);
      @(negedge ipClk);
      ipRxData  = b;
      ipRxValid = 1'b1;
      @(negedge ipClk);
      ipRxValid = 1'b0;
      ipRxData  = 8'd0;
   endtask

   task automatic checkTx(input string name, input int base, input logic [15:0] exp, input int n);
      check({name, " txcount"}, 64'(txLog.size() - base), 64'(n));
      for (int i = 0; i < n; i++) begin
         check({name, " txbyte"},
               (base + i < txLog.size()) ? 64'(txLog[base+i]) : 64'hDEAD,
               64'(exp[15-8*i -: 8]));
      end
   endtask

   typedef struct {
      string       name;
      logic [31:0] rx;
      int          nRx;
      int          expStrobes;
      logic [7:0]  expWrAddr;
      logic [63:0] expRegs;
      logic [15:0] tx;
      int          nTx;
   } vec_t;

   task automatic runVec(input vec_t v);
      int s0;
      int t0;
      s0 = strobeCount;
      t0 = txLog.size();
      for (int i = 0; i < v.nRx; i++) rxByte(v.rx[31-8*i -: 8]);
      repeat (60) @(negedge ipClk);
      check({v.name, " regs"}, opRegisters, v.expRegs);
      check({v.name, " strobes"}, 64'(strobeCount - s0), 64'(v.expStrobes));
      check({v.name, " wraddr"}, 64'(opWrAddress), 64'(v.expWrAddr));
      checkTx(v.name, t0, v.tx, v.nTx);
   endtask

   vec_t vecs [10];
   vec_t extra;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s0;
      int t0;
      int c0;
      vecs[0] = '{"garbage",  32'h4100_0000, 1, 0, 8'h00, 64'h0000_0000_0000_0000, 16'h0000, 0};
      vecs[1] = '{"wr2",      32'h5702_BEEF, 4, 1, 8'h02, 64'h0000_BEEF_0000_0000, 16'h0600, 1};
      vecs[2] = '{"rd2",      32'h5202_0000, 2, 0, 8'h02, 64'h0000_BEEF_0000_0000, 16'hBEEF, 2};
      vecs[3] = '{"wr_oor",   32'h5707_1234, 4, 0, 8'h02, 64'h0000_BEEF_0000_0000, 16'h1500, 1};
      vecs[4] = '{"rd_oor",   32'h5204_0000, 2, 0, 8'h02, 64'h0000_BEEF_0000_0000, 16'h1500, 1};
      vecs[5] = '{"wr1",      32'h5701_1234, 4, 1, 8'h01, 64'h0000_BEEF_1234_0000, 16'h0600, 1};
      vecs[6] = '{"rd1",      32'h5201_0000, 2, 0, 8'h01, 64'h0000_BEEF_1234_0000, 16'h1234, 2};
      vecs[7] = '{"wr0",      32'h5700_FFFF, 4, 1, 8'h00, 64'h0000_BEEF_1234_FFFF, 16'h0600, 1};
      vecs[8] = '{"rd_ff",    32'h52FF_0000, 2, 0, 8'h00, 64'h0000_BEEF_1234_FFFF, 16'h1500, 1};
      vecs[9] = '{"rd0",      32'h5200_0000, 2, 0, 8'h00, 64'h0000_BEEF_1234_FFFF, 16'hFFFF, 2};

      ipReset = 1'b1;
      repeat (3) @(posedge ipClk);
      @(negedge ipClk);
      check("reset regs", opRegisters, 64'd0);
      check("reset txdata", 64'(opTxData), 64'd0);
      check("reset txsend", 64'(opTxSend), 64'd0);
      check("reset strobe", 64'(opWrStrobe), 64'd0);
      check("reset wraddr", 64'(opWrAddress), 64'd0);
      ipReset = 1'b0;
      c0 = sendCycles;
      repeat (100) @(negedge ipClk);
      check("reset idle sends", 64'(sendCycles - c0), 64'd0);

      for (int i = 0; i < 10; i++) runVec(vecs[i]);

      // Bytes spaced just under the timeout still form one packet.
      s0 = strobeCount;
      t0 = txLog.size();
      rxByte(8'h57);
      rxByte(8'h03);
      repeat (990) @(negedge ipClk);
      rxByte(8'h12);
      repeat (990) @(negedge ipClk);
      rxByte(8'h34);
      repeat (60) @(negedge ipClk);
      check("slow wr3 regs", opRegisters, 64'h1234_BEEF_1234_FFFF);
      check("slow wr3 strobes", 64'(strobeCount - s0), 64'd1);
      checkTx("slow wr3", t0, 16'h0600, 1);

      // Partial packet abandoned by timeout.
      s0 = strobeCount;
      t0 = txLog.size();
      rxByte(8'h41);
      rxByte(8'h57);
      rxByte(8'h03);
      rxByte(8'hAA);
      repeat (1010) @(negedge ipClk);
      check("timeout strobes", 64'(strobeCount - s0), 64'd0);
      check("timeout txcount", 64'(txLog.size() - t0), 64'd0);
      check("timeout regs", opRegisters, 64'h1234_BEEF_1234_FFFF);

      // Fresh write after timeout, with commit latency checked cycle by cycle.
      t0 = txLog.size();
      rxByte(8'h57);
      rxByte(8'h03);
      rxByte(8'h00);
      rxByte(8'h01);
      check("commit cycle strobe", 64'(opWrStrobe), 64'd0);
      check("commit cycle regs", opRegisters, 64'h1234_BEEF_1234_FFFF);
      @(negedge ipClk);
      check("write edge strobe", 64'(opWrStrobe), 64'd1);
      check("write edge regs", opRegisters, 64'h0001_BEEF_1234_FFFF);
      check("write edge wraddr", 64'(opWrAddress), 64'd3);
      check("write edge txsend", 64'(opTxSend), 64'd1);
      @(negedge ipClk);
      check("strobe one cycle", 64'(opWrStrobe), 64'd0);
      repeat (60) @(negedge ipClk);
      checkTx("wr3 after timeout", t0, 16'h0600, 1);

      // A command byte arriving mid-response is dropped.
      t0 = txLog.size();
      rxByte(8'h52);
      rxByte(8'h00);
      for (int k = 0; k < 50 && txLog.size() <= t0; k++) @(negedge ipClk);
      rxByte(8'h57);
      repeat (60) @(negedge ipClk);
      checkTx("rd0 with drop", t0, 16'hFFFF, 2);
      extra = '{"after_drop", 32'h5201_0000, 2, 0, 8'h03, 64'h0001_BEEF_1234_FFFF, 16'h1234, 2};
      runVec(extra);

      // Reset while a response byte is being requested.
      rxByte(8'h52);
      rxByte(8'h00);
      for (int k = 0; k < 50 && !opTxSend; k++) @(negedge ipClk);
      check("send before reset", 64'(opTxSend), 64'd1);
      ipReset = 1'b1;
      @(negedge ipClk);
      check("midreset txsend", 64'(opTxSend), 64'd0);
      check("midreset regs", opRegisters, 64'd0);
      check("midreset wraddr", 64'(opWrAddress), 64'd0);
      ipReset = 1'b0;
      c0 = sendCycles;
      repeat (100) @(negedge ipClk);
      check("post reset sends", 64'(sendCycles - c0), 64'd0);

      check("tx handshake violations", 64'(protoErr), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
